// File: rtl/ibex_irq_gen_pkg.sv
// Shared types for the interrupt generator: the core's interrupt bundle and the
// register offsets of the software configuration port.
package ibex_irq_gen_pkg;

    typedef struct packed {
        logic        irq_software;
        logic        irq_timer;
        logic        irq_external;
        logic [14:0] irq_fast;
    } irqs_t;

    localparam int IRQ_NUM_SRC = $bits(irqs_t);

    typedef enum logic [4:0] {
        IRQ_GEN_ENABLE  = 5'h00,
        IRQ_GEN_MODE    = 5'h04,
        IRQ_GEN_PENDING = 5'h08,
        IRQ_GEN_RAW     = 5'h0C,
        IRQ_GEN_SET     = 5'h10
    } irq_gen_reg_e;

    function automatic logic [31:0] irq_gen_zext(input logic [IRQ_NUM_SRC-1:0] value);
        return {{(32 - IRQ_NUM_SRC){1'b0}}, value};
    endfunction

endpackage

// File: rtl/ibex_irq_gen_src.sv
// One interrupt source slice: synchroniser chain, edge detector and the pending
// flop with set-beats-clear priority in edge mode.
module ibex_irq_gen_src #(
    parameter int SyncStages = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic edge_mode,
    input  logic set,
    input  logic clr,
    output logic src_q,
    output logic pending
);

    logic prev;

    generate
        if (SyncStages == 0) begin : g_nosync
            assign src_q = src;
        end else begin : g_sync
            logic [SyncStages-1:0] sync_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= src;
                    for (int i = 1; i < SyncStages; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign src_q = sync_q[SyncStages-1];
        end
    endgenerate

    // Level mode simply mirrors the synchronised source; edge mode latches rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev    <= 1'b0;
            pending <= 1'b0;
        end else begin
            prev <= src_q;
            if (!edge_mode) begin
                pending <= src_q;
            end else if (set || (src_q && !prev)) begin
                pending <= 1'b1;
            end else if (clr) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ibex_irq_gen.sv
// Interrupt generator top: per-source slices, ENABLE/MODE configuration registers,
// register-port decode and the registered interrupt bundle to the core.
module ibex_irq_gen
    import ibex_irq_gen_pkg::*;
#(
    parameter int SyncStages = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [IRQ_NUM_SRC-1:0] src_i,
    output irqs_t                  irqs_o,
    input  logic                   reg_req_i,
    input  logic                   reg_we_i,
    input  logic [4:0]             reg_addr_i,
    input  logic [31:0]            reg_wdata_i,
    output logic                   reg_rvalid_o,
    output logic [31:0]            reg_rdata_o,
    output logic                   reg_err_o
);

    logic [4:0]             addr;
    logic                   wr;
    logic                   rd;
    logic [IRQ_NUM_SRC-1:0] wdata;
    logic [IRQ_NUM_SRC-1:0] en_q;
    logic [IRQ_NUM_SRC-1:0] edge_q;
    logic [IRQ_NUM_SRC-1:0] set_vec;
    logic [IRQ_NUM_SRC-1:0] clr_vec;
    logic [IRQ_NUM_SRC-1:0] src_q;
    logic [IRQ_NUM_SRC-1:0] pending;
    logic [31:0]            rdata_d;
    logic                   err_d;
    logic                   unused_bits;

    assign addr        = {reg_addr_i[4:2], 2'b00};
    assign wr          = reg_req_i & reg_we_i;
    assign rd          = reg_req_i & ~reg_we_i;
    assign wdata       = reg_wdata_i[IRQ_NUM_SRC-1:0];
    assign unused_bits = ^{reg_addr_i[1:0], reg_wdata_i[31:IRQ_NUM_SRC]};

    // Software set/clear only reaches bits currently in edge mode.
    assign set_vec = (wr && addr == IRQ_GEN_SET)     ? (wdata & edge_q) : '0;
    assign clr_vec = (wr && addr == IRQ_GEN_PENDING) ? (wdata & edge_q) : '0;

    generate
        for (genvar g = 0; g < IRQ_NUM_SRC; g++) begin : g_src
            ibex_irq_gen_src #(
                .SyncStages(SyncStages)
            ) u_src (
                .clk      (clk_i),
                .rst      (rst_i),
                .src      (src_i[g]),
                .edge_mode(edge_q[g]),
                .set      (set_vec[g]),
                .clr      (clr_vec[g]),
                .src_q    (src_q[g]),
                .pending  (pending[g])
            );
        end
    endgenerate

    always_comb begin
        rdata_d = '0;
        err_d   = 1'b0;
        case (addr)
            IRQ_GEN_ENABLE:  rdata_d = irq_gen_zext(en_q);
            IRQ_GEN_MODE:    rdata_d = irq_gen_zext(edge_q);
            IRQ_GEN_PENDING: rdata_d = irq_gen_zext(pending);
            IRQ_GEN_RAW:     rdata_d = irq_gen_zext(src_q);
            IRQ_GEN_SET:     rdata_d = '0;
            default:         err_d   = 1'b1;
        endcase
    end

    // Reads sample pre-update state, so the response reflects the request cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_q         <= '0;
            edge_q       <= '0;
            irqs_o       <= '0;
            reg_rvalid_o <= 1'b0;
            reg_rdata_o  <= '0;
            reg_err_o    <= 1'b0;
        end else begin
            if (wr && addr == IRQ_GEN_ENABLE) begin
                en_q <= wdata;
            end
            if (wr && addr == IRQ_GEN_MODE) begin
                edge_q <= wdata;
            end
            irqs_o       <= irqs_t'(pending & en_q);
            reg_rvalid_o <= reg_req_i;
            reg_rdata_o  <= rd ? rdata_d : '0;
            reg_err_o    <= reg_req_i & err_d;
        end
    end

endmodule

// File: tb/tb_ibex_irq_gen.sv
// Self-checking bench for ibex_irq_gen: directed latency/priority scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_ibex_irq_gen;
    import ibex_irq_gen_pkg::*;

    localparam int S = 2;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [17:0] src   = '0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [4:0]  addr  = '0;
    logic [31:0] wdata = '0;
    irqs_t       irqs;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] rd_x;
    logic        e_x;
    logic        v_x;

    always #5 clk = ~clk;

    ibex_irq_gen #(.SyncStages(S)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .src_i       (src),
        .irqs_o      (irqs),
        .reg_req_i   (req),
        .reg_we_i    (we),
        .reg_addr_i  (addr),
        .reg_wdata_i (wdata),
        .reg_rvalid_o(rvalid),
        .reg_rdata_o (rdata),
        .reg_err_o   (err)
    );

    // Behavioural reference: the source history is a delay line of raw samples,
    // and pending/enable/response are recomputed from the register-map rules.
    logic [17:0] m_en, m_mode, m_pend, m_prev, m_irq;
    logic [17:0] m_hist [4];
    logic        m_rvalid, m_err;
    logic [31:0] m_rdata;

    always @(posedge clk or posedge rst) begin : model
        logic [17:0] srcq, setv, clrv, rv;
        logic [4:0]  a;
        logic        wr_m, rd_m;
        if (rst) begin
            m_en = '0; m_mode = '0; m_pend = '0; m_prev = '0; m_irq = '0;
            for (int k = 0; k < 4; k++) m_hist[k] = '0;
            m_rvalid = 1'b0; m_err = 1'b0; m_rdata = '0;
        end else begin
            srcq = m_hist[S-1];
            a    = {addr[4:2], 2'b00};
            wr_m = req && we;
            rd_m = req && !we;
            setv = (wr_m && a == 5'h10) ? wdata[17:0] : '0;
            clrv = (wr_m && a == 5'h08) ? wdata[17:0] : '0;
            case (a)
                5'h00:   rv = m_en;
                5'h04:   rv = m_mode;
                5'h08:   rv = m_pend;
                5'h0C:   rv = srcq;
                default: rv = '0;
            endcase
            m_rvalid = req;
            m_rdata  = rd_m ? {14'b0, rv} : 32'h0;
            m_err    = req && (a > 5'h10);
            m_irq    = m_pend & m_en;
            m_pend   = (m_mode & (setv | (srcq & ~m_prev) | (m_pend & ~clrv))) | (~m_mode & srcq);
            m_prev   = srcq;
            for (int k = 3; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = src;
            if (wr_m && a == 5'h00) m_en = wdata[17:0];
            if (wr_m && a == 5'h04) m_mode = wdata[17:0];
        end
    end

    // Called at a negedge; returns at the next negedge with the response sampled.
    task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d,
                       output logic [31:0] r, output logic e, output logic v);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        r = rdata; e = err; v = rvalid;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic test_reset();
        logic [31:0] r; logic e, v;
        rst = 1'b1; src = 18'h3FFFF;
        repeat (3) @(negedge clk);
        n_cmp++; if (irqs !== 18'h0) begin n_fail++; $display("[TB] FAIL reset_irqs: got %h expected 0", irqs); end
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rvalid: got %b expected 0", rvalid); end
        n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
        rst = 1'b0;
        @(negedge clk);
        bus(1'b0, 5'h0C, 32'h0, r, e, v);
        n_cmp++; if (r !== 32'h0) begin n_fail++; $display("[TB] FAIL raw_early: got %h expected 0", r); end
        bus(1'b0, 5'h0C, 32'h0, r, e, v);
        n_cmp++; if (r !== 32'h3FFFF || v !== 1'b1 || e !== 1'b0) begin n_fail++; $display("[TB] FAIL raw_synced: got %h/v%b/e%b expected 3ffff/v1/e0", r, v, e); end
    endtask

    task automatic test_level();
        src = '0;
        repeat (4) @(negedge clk);
        bus(1'b1, 5'h04, 32'h0, rd_x, e_x, v_x);
        bus(1'b1, 5'h00, 32'h10000, rd_x, e_x, v_x);
        src[16] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_cmp++; if (irqs.irq_timer !== (k >= 4)) begin n_fail++; $display("[TB] FAIL level_rise_%0d: got %b expected %b", k, irqs.irq_timer, (k >= 4)); end
        end
        src[16] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_cmp++; if (irqs.irq_timer !== (k < 4)) begin n_fail++; $display("[TB] FAIL level_fall_%0d: got %b expected %b", k, irqs.irq_timer, (k < 4)); end
        end
    endtask

    task automatic test_edge();
        bus(1'b1, 5'h04, 32'h8, rd_x, e_x, v_x);
        bus(1'b1, 5'h00, 32'h8, rd_x, e_x, v_x);
        src[3] = 1'b1;
        @(negedge clk);
        src[3] = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++; if (irqs !== 18'h8) begin n_fail++; $display("[TB] FAIL edge_latched: got %h expected 00008", irqs); end
        bus(1'b1, 5'h08, 32'h8, rd_x, e_x, v_x);
        n_cmp++; if (irqs.irq_fast[3] !== 1'b1) begin n_fail++; $display("[TB] FAIL edge_clear_lag: got %b expected 1", irqs.irq_fast[3]); end
        @(negedge clk);
        n_cmp++; if (irqs.irq_fast[3] !== 1'b0) begin n_fail++; $display("[TB] FAIL edge_cleared: got %b expected 0", irqs.irq_fast[3]); end
    endtask

    task automatic test_collision();
        logic [31:0] r; logic e, v;
        bus(1'b1, 5'h04, 32'h1, rd_x, e_x, v_x);
        bus(1'b1, 5'h00, 32'h0, rd_x, e_x, v_x);
        src[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus(1'b1, 5'h08, 32'h1, rd_x, e_x, v_x);
        bus(1'b0, 5'h08, 32'h0, r, e, v);
        n_cmp++; if (r !== 32'h1) begin n_fail++; $display("[TB] FAIL set_beats_clear: got %h expected 1", r); end
        src[0] = 1'b0;
        bus(1'b1, 5'h08, 32'h1, rd_x, e_x, v_x);
        bus(1'b0, 5'h08, 32'h0, r, e, v);
        n_cmp++; if (r !== 32'h0) begin n_fail++; $display("[TB] FAIL w1c_clear: got %h expected 0", r); end
        bus(1'b1, 5'h10, 32'h21, rd_x, e_x, v_x);
        bus(1'b0, 5'h08, 32'h0, r, e, v);
        n_cmp++; if (r !== 32'h1) begin n_fail++; $display("[TB] FAIL set_edge_only: got %h expected 1", r); end
        n_cmp++; if (irqs.irq_fast[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL set_disabled: got %b expected 0", irqs.irq_fast[0]); end
        bus(1'b1, 5'h00, 32'h1, rd_x, e_x, v_x);
        n_cmp++; if (irqs.irq_fast[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL enable_lag: got %b expected 0", irqs.irq_fast[0]); end
        @(negedge clk);
        n_cmp++; if (irqs.irq_fast[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL enable_assert: got %b expected 1", irqs.irq_fast[0]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic e, v;
        req = 1'b1; we = 1'b1; addr = 5'h00; wdata = 32'hFFFFFFFF;
        @(negedge clk);
        n_cmp++; if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL b2b_wr_resp: got v%b e%b %h expected v1 e0 0", rvalid, err, rdata); end
        we = 1'b0; wdata = '0;
        @(negedge clk);
        n_cmp++; if (rvalid !== 1'b1 || rdata !== 32'h3FFFF) begin n_fail++; $display("[TB] FAIL b2b_rd_resp: got v%b %h expected v1 3ffff", rvalid, rdata); end
        req = 1'b0;
        @(negedge clk);
        n_cmp++; if (rvalid !== 1'b0 || rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL rvalid_pulse: got v%b %h expected v0 0", rvalid, rdata); end
        bus(1'b0, 5'h14, 32'h0, r, e, v);
        n_cmp++; if (r !== 32'h0 || e !== 1'b1) begin n_fail++; $display("[TB] FAIL unmapped_rd: got %h e%b expected 0 e1", r, e); end
        bus(1'b0, 5'h10, 32'h0, r, e, v);
        n_cmp++; if (r !== 32'h0 || e !== 1'b0) begin n_fail++; $display("[TB] FAIL set_reads0: got %h e%b expected 0 e0", r, e); end
        bus(1'b1, 5'h1C, 32'h0, r, e, v);
        n_cmp++; if (e !== 1'b1) begin n_fail++; $display("[TB] FAIL unmapped_wr_err: got %b expected 1", e); end
        bus(1'b0, 5'h03, 32'h0, r, e, v);
        n_cmp++; if (r !== 32'h3FFFF) begin n_fail++; $display("[TB] FAIL low_addr_ignored: got %h expected 3ffff", r); end
    endtask

    task automatic test_random();
        logic [31:0] t, u;
        for (int c = 0; c < 400; c++) begin
            n_cmp++; if (irqs !== m_irq) begin n_fail++; $display("[TB] FAIL rand_irqs c%0d: got %h expected %h", c, irqs, m_irq); end
            n_cmp++; if (rvalid !== m_rvalid || err !== m_err) begin n_fail++; $display("[TB] FAIL rand_resp c%0d: got v%b e%b expected v%b e%b", c, rvalid, err, m_rvalid, m_err); end
            n_cmp++; if (rdata !== m_rdata) begin n_fail++; $display("[TB] FAIL rand_rdata c%0d: got %h expected %h", c, rdata, m_rdata); end
            t = $urandom;
            u = $urandom;
            if (t[31:30] == 2'b00) src = src ^ u[17:0];
            req   = t[0] | t[1];
            we    = t[2];
            addr  = t[7:3];
            wdata = $urandom;
            @(negedge clk);
        end
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic test_async_reset();
        logic [31:0] r; logic e, v;
        bus(1'b1, 5'h04, 32'h3FFFF, rd_x, e_x, v_x);
        bus(1'b1, 5'h00, 32'h3FFFF, rd_x, e_x, v_x);
        bus(1'b1, 5'h10, 32'h3FFFF, rd_x, e_x, v_x);
        @(negedge clk);
        n_cmp++; if (irqs !== 18'h3FFFF) begin n_fail++; $display("[TB] FAIL all_pending: got %h expected 3ffff", irqs); end
        req = 1'b1; we = 1'b0; addr = 5'h08;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (irqs !== 18'h0 || rvalid !== 1'b0 || rdata !== 32'h0 || err !== 1'b0) begin n_fail++; $display("[TB] FAIL async_reset: got %h v%b %h e%b expected all 0", irqs, rvalid, rdata, err); end
        @(negedge clk);
        req = 1'b0; addr = '0; src = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (rvalid !== 1'b0 || irqs !== 18'h0) begin n_fail++; $display("[TB] FAIL post_reset_idle: got v%b %h expected v0 0", rvalid, irqs); end
        bus(1'b0, 5'h00, 32'h0, r, e, v);
        n_cmp++; if (v !== 1'b1 || r !== 32'h0 || e !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_req: got v%b %h e%b expected v1 0 e0", v, r, e); end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_level();
        test_edge();
        test_collision();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
